// File: rtl/spi_ctrl_pkg.sv
// Shared constants, frame payload layout and FSM state encodings for the SPI
// register-write controller that drives the onboarding peripheral.
package spi_ctrl_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned BIT_CNT_W  = 4;
  localparam int unsigned TICK_CNT_W = 8;

  typedef logic [2:0] state_t;
  localparam state_t IDLE  = 3'd0;
  localparam state_t SETUP = 3'd1;
  localparam state_t SHIFT = 3'd2;
  localparam state_t HOLD  = 3'd3;
  localparam state_t GAP   = 3'd4;

  // On-wire frame, MSB first: {rw, addr, data}
  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } spi_frame_t;

  localparam logic [ADDR_W-1:0] REG_EN_OUT  = 7'h00;
  localparam logic [ADDR_W-1:0] REG_EN_UIO  = 7'h01;
  localparam logic [ADDR_W-1:0] REG_PWM_OUT = 7'h02;
  localparam logic [ADDR_W-1:0] REG_PWM_UIO = 7'h03;
  localparam logic [ADDR_W-1:0] REG_DUTY    = 7'h04;

endpackage

// File: rtl/spi_half_tick.sv
// Half-period timebase: tick_c fires every CLK_DIV cycles while enabled; the
// counter sits at its reload value whenever disabled, so each enable restarts it.
module spi_half_tick
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick_c
);

  localparam logic [TICK_CNT_W-1:0] RELOAD = TICK_CNT_W'(CLK_DIV - 1);

  logic [TICK_CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= RELOAD;
    end else if (!en || (cnt == '0)) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick_c = en && (cnt == '0);

endmodule

// File: rtl/spi_ctrl_writer.sv
// SPI mode-0 controller: accepts one {rw, addr, data} request and serialises it
// MSB-first on ncs/sclk/copi, then pulses done once the inter-frame gap ends.
module spi_ctrl_writer
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              busy,
  output logic              done,
  output logic              spi_ncs,
  output logic              spi_sclk,
  output logic              spi_copi
);

  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(FRAME_BITS - 1);

  state_t                 state, state_nxt;
  logic [FRAME_BITS-1:0]  shreg, shreg_nxt;
  logic [BIT_CNT_W-1:0]   bit_cnt, bit_cnt_nxt;
  logic                   ready_nxt, done_nxt, ncs_nxt, sclk_nxt, copi_nxt;
  logic                   tick_en, tick_c;
  spi_frame_t             req_frame;

  assign req_frame = '{rw: req_rw, addr: req_addr, data: req_data};
  assign tick_en   = (state != IDLE);

  spi_half_tick #(.CLK_DIV(CLK_DIV)) u_half_tick (
    .clk    (clk),
    .rst    (rst),
    .en     (tick_en),
    .tick_c (tick_c)
  );

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      spi_ncs   <= 1'b1;
      spi_sclk  <= 1'b0;
      spi_copi  <= 1'b0;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      bit_cnt   <= bit_cnt_nxt;
      req_ready <= ready_nxt;
      busy      <= ~ready_nxt;
      done      <= done_nxt;
      spi_ncs   <= ncs_nxt;
      spi_sclk  <= sclk_nxt;
      spi_copi  <= copi_nxt;
    end
  end

  // Next-state and next-output decode; SCLK high half comes first in SHIFT
  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    done_nxt    = 1'b0;
    ncs_nxt     = spi_ncs;
    sclk_nxt    = spi_sclk;
    copi_nxt    = spi_copi;

    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nxt   = SETUP;
          shreg_nxt   = req_frame;
          bit_cnt_nxt = '0;
          ncs_nxt     = 1'b0;
          sclk_nxt    = 1'b0;
          copi_nxt    = req_frame.rw;
        end
      end
      SETUP: begin
        if (tick_c) begin
          state_nxt = SHIFT;
          sclk_nxt  = 1'b1;
        end
      end
      SHIFT: begin
        if (tick_c) begin
          if (!spi_sclk) begin
            sclk_nxt = 1'b1;
          end else begin
            sclk_nxt = 1'b0;
            // Last falling edge keeps copi on bit 0 through HOLD
            if (bit_cnt == BIT_LAST) begin
              state_nxt = HOLD;
            end else begin
              bit_cnt_nxt = bit_cnt + 1'b1;
              shreg_nxt   = {shreg[FRAME_BITS-2:0], 1'b0};
              copi_nxt    = shreg[FRAME_BITS-2];
            end
          end
        end
      end
      HOLD: begin
        if (tick_c) begin
          state_nxt = GAP;
          ncs_nxt   = 1'b1;
          copi_nxt  = 1'b0;
        end
      end
      GAP: begin
        if (tick_c) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        ncs_nxt   = 1'b1;
        sclk_nxt  = 1'b0;
        copi_nxt  = 1'b0;
      end
    endcase

    ready_nxt = (state_nxt == IDLE);
  end

endmodule
